// File: rtl/ifetch_queue.sv
// -----------------------------------------------------------------------------
// ifetch_queue
//
// Decoupled instruction-fetch stage. It owns the PC and issues one word fetch at
// a time to instruction memory over a req/gnt/rvalid handshake. Returned words
// are buffered in a DEPTH-entry FIFO that feeds ID over a valid/ready handshake.
//
// ERET, exception and branch redirects retarget the PC and flush the queue. A
// response that is still in flight when the redirect happens is discarded.
//
// A PC that is misaligned or outside [TEXT_LO, TEXT_HI] is never fetched.
// Instead, an AdEL entry (ExcCode 4, instr 0) is queued and fetching halts until
// the next redirect.
//
// Ports
//   clk, reset         rising-edge clock; asynchronous active-low reset
//   redir_epc, epc     ERET redirect and its target (highest priority)
//   redir_exc          exception redirect to HANDLER_PC
//   redir_br,br_target branch/jump redirect and its target (lowest priority)
//   imem_req/addr      fetch request and word address
//   imem_gnt           request accepted this cycle
//   imem_rvalid/rdata  one response per grant, at least one cycle later
//   id_valid/id_ready  queue head handshake toward ID
//   id_pc/instr/exccode head entry fields (all zero while the queue is empty)
//   q_count            current queue occupancy
// -----------------------------------------------------------------------------
module ifetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_4FFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redir_epc,
  input  logic [31:0]                epc,
  input  logic                       redir_exc,
  input  logic                       redir_br,
  input  logic [31:0]                br_target,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_instr,
  output logic [4:0]                 id_exccode,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  typedef enum logic [1:0] {
    S_ISSUE,  // may request pc_q
    S_WAIT,   // one grant outstanding, response will be queued
    S_DRAIN,  // one grant outstanding, response will be dropped
    S_HALT    // AdEL queued, wait for a redirect
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exccode;
  } entry_t;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             mem_q [DEPTH];

  logic               redirect;
  logic [31:0]        redir_target;
  logic               pc_legal;
  logic               not_full;
  logic               can_req;
  logic               grant;
  logic               push_raw;
  logic               push;
  logic               pop;
  entry_t             push_entry;
  entry_t             head;

  // Redirect target, ERET over exception over branch.
  always_comb begin
    redir_target = br_target;
    if (redir_epc)      redir_target = epc;
    else if (redir_exc) redir_target = HANDLER_PC;
  end

  assign redirect = redir_epc | redir_exc | redir_br;
  assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q >= TEXT_LO) && (pc_q <= TEXT_HI);
  assign not_full = count_q < CNT_W'(DEPTH);
  assign can_req  = (state_q == S_ISSUE) && pc_legal && not_full;

  // A redirect withdraws the request unless memory grants it in the same cycle.
  // In that case the grant stands, and its response is drained later.
  // The reset term only keeps the port quiet while reset is held; the state
  // flops are already forced by the asynchronous reset.
  assign imem_req  = reset && can_req && (!redirect || imem_gnt);
  assign grant     = can_req && (!redirect || imem_gnt) && imem_gnt;
  assign imem_addr = pc_q;

  // Fetch FSM: next state, PC and queue push.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    push_raw   = 1'b0;
    push_entry = '0;

    case (state_q)
      S_ISSUE: begin
        if (grant) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end else if (!pc_legal && not_full) begin
          push_raw   = 1'b1;
          push_entry = '{pc: pc_q, instr: 32'h0, exccode: EXC_ADEL};
          state_d    = S_HALT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push_raw   = 1'b1;
          push_entry = '{pc: req_pc_q, instr: imem_rdata, exccode: 5'd0};
          state_d    = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_d = S_ISSUE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_ISSUE;
    endcase

    // A redirect overrides the PC. It also decides whether a grant is still
    // owed a response, in which case the next state is DRAIN.
    if (redirect) begin
      pc_d = redir_target;
      case (state_q)
        S_ISSUE:         state_d = grant ? S_DRAIN : S_ISSUE;
        S_WAIT, S_DRAIN: state_d = imem_rvalid ? S_ISSUE : S_DRAIN;
        default:         state_d = S_ISSUE;
      endcase
    end
  end

  // Queue bookkeeping. A redirect flushes the queue and cancels this cycle's
  // push and pop.
  assign id_valid = (count_q != '0);
  assign push     = push_raw && !redirect;
  assign pop      = id_valid && id_ready && !redirect;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so that every flop samples
  // pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_ISSUE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: queue storage is deliberately not reset. An entry is only read once
  // count_q says it was written, and the outputs are zeroed while the queue is
  // empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head       = mem_q[rd_ptr_q];
  assign id_pc      = id_valid ? head.pc      : 32'h0;
  assign id_instr   = id_valid ? head.instr   : 32'h0;
  assign id_exccode = id_valid ? head.exccode : 5'd0;
  assign q_count    = count_q;

endmodule
